// File: rtl/scale_pkg.sv
// Shared definitions for the scale_mux / scale_demux pair: lane select
// encoding and default widths.
package scale_pkg;

    typedef logic lane_sel_t;

    localparam lane_sel_t LANE_A = 1'b0;
    localparam lane_sel_t LANE_B = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/scale_demux_lane.sv
// One output lane of scale_demux: DEPTH-entry circular buffer with
// valid/ready output and a saturating delivered-beat counter.
module scale_demux_lane
    import scale_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             can_push,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty, full, pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    // Suppressing valid during reset guarantees no beat is delivered in that cycle.
    assign out_valid = !empty && !rst;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign pop       = out_valid && out_ready;
    assign can_push  = !full || pop;
    assign cnt       = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never observed while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/scale_demux.sv
// 1:2 valid/ready demultiplexer: each input beat is steered to lane A or B
// by in_sel_b; each lane buffers and drains independently.
module scale_demux
    import scale_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    lane_sel_t sel;
    logic      a_can_push, b_can_push;
    logic      push_a, push_b;

    always_comb begin
        // Select is only trusted with a beat present, so an X select never leaks.
        sel      = in_valid ? lane_sel_t'(in_sel_b) : LANE_A;
        in_ready = !rst && ((sel == LANE_B) ? b_can_push : a_can_push);
        push_a   = in_valid && in_ready && (sel == LANE_A);
        push_b   = in_valid && in_ready && (sel == LANE_B);
    end

    scale_demux_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .push_data (in_data),
        .can_push  (a_can_push),
        .out_data  (out_a_data),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .cnt       (cnt_a)
    );

    scale_demux_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .push_data (in_data),
        .can_push  (b_can_push),
        .out_data  (out_b_data),
        .out_valid (out_b_valid),
        .out_ready (out_b_ready),
        .cnt       (cnt_b)
    );

endmodule

// File: doc/scale_demux.md
Name: scale_demux

Overview:
- Sequential counterpart of the scale_mux 2:1 combiner: one WIDTH-bit valid/ready input stream is steered to output A or output B by a per-beat select bit.
- Each output lane has a 2-entry buffer, so the lanes drain independently and a stalled lane does not block traffic to the other lane.
- Sits between a single producer and two scale-domain consumers.
- Per-lane saturating beat counters provide debug and verification visibility.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- DEPTH, 2, entries per lane buffer; legal values are 2 or 4 (power of two).
- CNT_W, 16, width of each per-lane beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  input beat data.
- in_sel_b  in  1  0 routes the beat to lane A, 1 routes it to lane B; sampled with the beat.
- in_valid  in  1  input beat present.
- in_ready  out  1  input beat accepted this cycle when in_valid & in_ready.
- out_a_data  out  WIDTH  lane A head data.
- out_a_valid  out  1  lane A non-empty.
- out_a_ready  in  1  lane A consumer accepts.
- out_b_data  out  WIDTH  lane B head data.
- out_b_valid  out  1  lane B non-empty.
- out_b_ready  in  1  lane B consumer accepts.
- cnt_a  out  CNT_W  beats delivered on lane A (out_a_valid & out_a_ready).
- cnt_b  out  CNT_W  beats delivered on lane B.

Behaviour:
- Reset (rst=1 at a clk edge): both lanes emptied, pointers set to 0, out_*_valid=0, out_*_data=0, cnt_a=cnt_b=0.
- in_ready is also held 0 while rst=1.
- A reset asserted mid-transfer discards buffered beats; no beat is delivered in the reset cycle.
- in_ready is combinational: it equals !full of the lane picked by in_sel_b, and is 1 when that lane is full but popping this cycle.
- in_ready never depends on the non-selected lane.
- Accept: in_valid & in_ready pushes in_data into the selected lane at the clk edge.
- Latency: an accepted beat appears on out_x_valid/out_x_data the next cycle at the earliest, so there is no combinational in-to-out data path.
- Lane buffer:
  - Circular buffer of DEPTH entries with wrapping read and write pointers (log2(DEPTH) bits) plus an occupancy count of 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - out_x_valid = !empty; out_x_data = entry at the read pointer, and holds 0 when empty.
- Simultaneous push and pop on the same lane: count is unchanged and both pointers advance. This is legal when full (pop frees the slot) and when empty only if the entry was written earlier, i.e. there is no bypass.
- Pop on empty is ignored. Push on full without a simultaneous pop cannot occur because in_ready=0.
- Ordering: beats on each lane leave in acceptance order. Relative order between lanes is not preserved.
- Throughput: 1 beat/cycle sustained to a lane whose consumer holds ready=1.
- Counters: cnt_x increments on each out_x handshake and saturates at all-ones (2^CNT_W-1). There is no wrap.
- in_sel_b and in_data only matter while in_valid=1. X on them with in_valid=0 must not propagate.
- Protocol: out_x_data/out_x_valid stay stable while out_x_valid=1 and out_x_ready=0. The upstream producer obeys the same rule.

Decomposition:
- Package scale_pkg:
  - LANE_A=1'b0 and LANE_B=1'b1 select constants.
  - typedef lane_sel_t.
  - Default WIDTH/CNT_W localparams shared with scale_mux.
- Sub-module scale_demux_lane holds the DEPTH-entry circular buffer, pointer/count logic and the saturating counter. It is instantiated twice.
- The top level contains only select decode, in_ready generation and push steering.

Test Plan:
- Reset then idle, both readies=1 -> out_a_valid=out_b_valid=0, in_ready=1, cnt_a=cnt_b=0.
- Push 8'h11 sel=0 then 8'h22 sel=1, readies=1 -> cycle+1 out_a_data=8'h11, next cycle out_b_data=8'h22; cnt_a=1, cnt_b=1.
- out_a_ready=0, push 8'h01,8'h02 to A (DEPTH=2) -> in_ready=0 for sel=0 but 1 for sel=1; push 8'hFF sel=1 delivered on B. Then release A -> 8'h01 then 8'h02 in order.
- A full, out_a_ready=1 and push sel=0 in same cycle -> accepted, count stays 2; the stream 8'h00..8'h0F delivered in order at 1 beat/cycle.
- Assert rst for 1 cycle with 2 beats in lane B -> next cycle out_b_valid=0, cnt_b=0; no beat of the old data is delivered after reset.
- CNT_W=4, 20 beats to lane A -> cnt_a stops at 4'hF.
